// File: rtl/rotate_commit.sv
// Rotation commit controller: sends the piece to an external rotator, fetches four
// board rows, then tries kicks 0/-1/+1 and commits the first placement that fits.
module rotate_commit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_dir,
  input  logic [0:15] float_in,
  input  logic [4:0]  pos_x,
  input  logic [4:0]  pos_y,
  output logic [0:15] rot_float,
  output logic        rot_dir,
  input  logic [0:15] rot_result,
  output logic [4:0]  row_addr,
  input  logic [9:0]  row_data,
  output logic        busy,
  output logic        done,
  output logic        accepted,
  output logic [0:15] new_float,
  output logic [4:0]  new_pos_x
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [0:15]      rot_float_q, rot_float_d;
  logic             rot_dir_q, rot_dir_d;
  logic [4:0]       pos_x_q, pos_x_d;
  logic [4:0]       pos_y_q, pos_y_d;
  logic [0:15]      cand_q, cand_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [4:0]       row_addr_q, row_addr_d;
  logic [3:0][9:0]  rowbuf_q, rowbuf_d;
  logic             accepted_q, accepted_d;
  logic [0:15]      new_float_q, new_float_d;
  logic [4:0]       new_pos_x_q, new_pos_x_d;

  logic signed [5:0] off;
  logic signed [5:0] col;
  logic              hit;
  logic [1:0]        fidx;
  logic [4:0]        faddr;

  // cnt_q doubles as the fetch cycle counter and the kick index
  always_comb begin
    case (cnt_q)
      3'd0:    off = 6'sd0;
      3'd1:    off = -6'sd1;
      default: off = 6'sd1;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    col = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        col = $signed({pos_x_q[4], pos_x_q}) + off + 6'(j);
        if (cand_q[i*4+j]) begin
          if (col < 6'sd0 || col > 6'sd9) hit = 1'b1;
          else if (rowbuf_q[i][col[3:0]]) hit = 1'b1;
        end
      end
    end
  end

  assign fidx  = 2'(cnt_q - 3'd1);
  assign faddr = pos_y_q + 5'(fidx);

  always_comb begin
    state_d     = state_q;
    rot_float_d = rot_float_q;
    rot_dir_d   = rot_dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    row_addr_d  = row_addr_q;
    rowbuf_d    = rowbuf_q;
    accepted_d  = accepted_q;
    new_float_d = new_float_q;
    new_pos_x_d = new_pos_x_q;
    case (state_q)
      S_IDLE: if (req) begin
        rot_float_d = float_in;
        rot_dir_d   = req_dir;
        pos_x_d     = pos_x;
        pos_y_d     = pos_y;
        state_d     = S_LOAD;
      end
      S_LOAD: state_d = S_CAPTURE;
      S_CAPTURE: begin
        cand_d     = rot_result;
        cnt_d      = 3'd0;
        row_addr_d = pos_y_q;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q < 3'd3) row_addr_d = pos_y_q + 5'(cnt_q) + 5'd1;
        // rows past the bottom of the board (incl. wrap) act as solid floor
        if (cnt_q != 3'd0) rowbuf_d[fidx] = (faddr > 5'd19) ? '1 : row_data;
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_CHECK: begin
        if (!hit) begin
          accepted_d  = 1'b1;
          new_float_d = cand_q;
          new_pos_x_d = pos_x_q + off[4:0];
          state_d     = S_DONE;
        end else if (cnt_q == 3'd2) begin
          accepted_d  = 1'b0;
          new_float_d = rot_float_q;
          new_pos_x_d = pos_x_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rot_float_q <= '0;
      rot_dir_q   <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      row_addr_q  <= '0;
      rowbuf_q    <= '0;
      accepted_q  <= 1'b0;
      new_float_q <= '0;
      new_pos_x_q <= '0;
    end else begin
      state_q     <= state_d;
      rot_float_q <= rot_float_d;
      rot_dir_q   <= rot_dir_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      row_addr_q  <= row_addr_d;
      rowbuf_q    <= rowbuf_d;
      accepted_q  <= accepted_d;
      new_float_q <= new_float_d;
      new_pos_x_q <= new_pos_x_d;
    end
  end

  assign rot_float = rot_float_q;
  assign rot_dir   = rot_dir_q;
  assign row_addr  = row_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign accepted  = accepted_q;
  assign new_float = new_float_q;
  assign new_pos_x = new_pos_x_q;
endmodule

// File: tb/tb_rotate_commit.sv
// Bench for rotate_commit: emulates the registered rotator and board RAM, predicts
// each outcome from the kick rules and checks outputs on every falling edge.
module tb_rotate_commit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_dir = 1'b0;
  logic [0:15] float_in = '0;
  logic [4:0]  pos_x = '0;
  logic [4:0]  pos_y = '0;
  logic [0:15] rot_float;
  logic        rot_dir;
  logic [0:15] rot_result;
  logic [4:0]  row_addr;
  logic [9:0]  row_data;
  logic        busy, done, accepted;
  logic [0:15] new_float;
  logic [4:0]  new_pos_x;

  rotate_commit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dir(req_dir), .float_in(float_in),
    .pos_x(pos_x), .pos_y(pos_y), .rot_float(rot_float), .rot_dir(rot_dir),
    .rot_result(rot_result), .row_addr(row_addr), .row_data(row_data), .busy(busy),
    .done(done), .accepted(accepted), .new_float(new_float), .new_pos_x(new_pos_x)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [9:0] board [0:31];

  // expected transaction, owned by the stimulus process
  int          req_cyc = -100;
  int          done_cyc = -100;
  logic        exp_acc = 1'b0;
  logic [0:15] exp_nf = '0;
  logic [4:0]  exp_npx = '0;
  logic [0:15] exp_rf = '0;
  logic        exp_rd = 1'b0;

  // values the outputs must be holding, owned by the compare process
  logic        h_acc = 1'b0;
  logic [0:15] h_nf = '0;
  logic [4:0]  h_npx = '0;

  function automatic logic [0:15] rotate(input logic [0:15] f, input logic d);
    logic [0:15] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i*4+j] = d ? f[j*4+3-i] : f[(3-j)*4+i];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rot_result <= rotate(rot_float, rot_dir);
    row_data   <= board[row_addr];
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // Reference: try each kick with plain integer board coordinates.
  task automatic model(input logic [0:15] f, input logic d, input logic [4:0] px,
                       input logic [4:0] py, output logic acc, output logic [0:15] nf,
                       output logic [4:0] npx, output int k);
    logic [0:15] cand;
    int sx, off, c, r;
    bit ok;
    cand = rotate(f, d);
    sx = (px >= 16) ? int'(px) - 32 : int'(px);
    acc = 1'b0; nf = f; npx = px; k = 2;
    for (int kk = 0; kk < 3 && !acc; kk++) begin
      off = (kk == 0) ? 0 : (kk == 1) ? -1 : 1;
      ok = 1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (cand[i*4+j]) begin
            c = sx + off + j;
            r = (int'(py) + i) % 32;
            if (c < 0 || c > 9 || r > 19) ok = 0;
            else if (board[r][c]) ok = 0;
          end
      if (ok) begin
        acc = 1'b1; nf = cand; npx = 5'((sx + off) & 31); k = kk;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      h_acc = 1'b0; h_nf = '0; h_npx = '0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_acc", accepted, 0);
      check("rst_nf", new_float, 0);
      check("rst_npx", new_pos_x, 0);
      check("rst_rf", rot_float, 0);
      check("rst_rd", rot_dir, 0);
      check("rst_addr", row_addr, 0);
    end else begin
      if (cyc == done_cyc) begin
        h_acc = exp_acc; h_nf = exp_nf; h_npx = exp_npx;
      end
      check("busy", busy, (cyc >= req_cyc && cyc <= done_cyc));
      check("done", done, (cyc == done_cyc));
      check("accepted", accepted, h_acc);
      check("new_float", new_float, h_nf);
      check("new_pos_x", new_pos_x, h_npx);
      check("rot_float", rot_float, exp_rf);
      check("rot_dir", rot_dir, exp_rd);
    end
  end

  // pulse_at: extra req sampled this many edges after the accepted one (0 = none)
  task automatic do_req(input logic [0:15] f, input logic d, input logic [4:0] px,
                        input logic [4:0] py, input bit scramble, input int pulse_at);
    logic acc; logic [0:15] nf; logic [4:0] npx; int k;
    @(negedge clk); #1;
    model(f, d, px, py, acc, nf, npx, k);
    float_in = f; req_dir = d; pos_x = px; pos_y = py; req = 1'b1;
    exp_rf = f; exp_rd = d; exp_acc = acc; exp_nf = nf; exp_npx = npx;
    req_cyc = cyc + 1;
    done_cyc = req_cyc + 8 + k;
    @(negedge clk); #1;
    req = 1'b0;
    while (cyc <= done_cyc) begin
      if (scramble) begin
        float_in = 16'($urandom); req_dir = 1'($urandom);
        pos_x = 5'($urandom); pos_y = 5'($urandom);
        req = ($urandom_range(0, 2) == 0);
      end else begin
        req = (pulse_at != 0 && cyc + 1 == req_cyc + pulse_at);
      end
      @(negedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < 32; r++) board[r] = (r > 19) ? 10'($urandom) : '0;
  endtask

  task automatic pin(input string nm, input logic [0:15] f, input logic [4:0] px,
                     input logic [4:0] py, input logic e_acc, input logic [0:15] e_nf,
                     input logic [4:0] e_npx, input int e_k);
    logic acc; logic [0:15] nf; logic [4:0] npx; int k;
    model(f, 1'b0, px, py, acc, nf, npx, k);
    check({nm, "_acc"}, acc, e_acc);
    check({nm, "_nf"}, nf, e_nf);
    check({nm, "_npx"}, npx, e_npx);
    check({nm, "_lat"}, 9 + k, 9 + e_k);
  endtask

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    pin("pin_basic", 16'h0F00, 5'd3, 5'd0, 1'b1, 16'h2222, 5'd3, 0);
    do_req(16'h0F00, 1'b0, 5'd3, 5'd0, 0, 0);
    pin("pin_wall", 16'h0F00, 5'd8, 5'd0, 1'b1, 16'h2222, 5'd7, 1);
    do_req(16'h0F00, 1'b0, 5'd8, 5'd0, 0, 0);
    pin("pin_floor", 16'h0F00, 5'd3, 5'd18, 1'b0, 16'h0F00, 5'd3, 2);
    do_req(16'h0F00, 1'b0, 5'd3, 5'd18, 0, 0);
    board[2][5] = 1'b1;
    pin("pin_block", 16'h0F00, 5'd3, 5'd0, 1'b1, 16'h2222, 5'd2, 1);
    do_req(16'h0F00, 1'b0, 5'd3, 5'd0, 0, 0);
    clear_board();

    // second request during the operation must be dropped
    do_req(16'h0F00, 1'b1, 5'd4, 5'd2, 0, 3);
    repeat (4) @(negedge clk);

    // reset in the middle of the row fetch
    @(negedge clk); #1;
    float_in = 16'h0F00; req_dir = 1'b0; pos_x = 5'd3; pos_y = 5'd0; req = 1'b1;
    exp_rf = 16'h0F00; exp_rd = 1'b0; exp_acc = 1'b1; exp_nf = 16'h2222; exp_npx = 5'd3;
    req_cyc = cyc + 1; done_cyc = req_cyc + 8;
    @(negedge clk); #1 req = 1'b0;
    while (cyc < req_cyc + 4) @(negedge clk);
    #1;
    req_cyc = -100; done_cyc = -100; exp_rf = '0; exp_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rf", rot_float, 0);
    check("midrst_addr", row_addr, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_req(16'h0F00, 1'b0, 5'd3, 5'd0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 10; c++)
          board[r][c] = (r > 19) ? 1'($urandom) : ($urandom_range(0, 5) == 0);
      do_req(16'($urandom), 1'($urandom), 5'($urandom_range(0, 12) - 2 & 31),
             5'($urandom), (t % 2) == 1, 0);
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rotate_commit.md
ROTATE_COMMIT -- requirements
Module: rotate_commit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 req  input  1  rotation request, sampled only in IDLE.
REQ-004 req_dir  input  1  0 = clockwise, 1 = counter-clockwise.
REQ-005 float_in  input  [0:15]  current 4x4 piece; bit i*4+j = window row i, column j.
REQ-006 pos_x  input  5  signed two's-complement board column of window column 0.
REQ-007 pos_y  input  5  unsigned board row of window row 0.
REQ-008 rot_float  output  [0:15]  piece driven to the external registered rotator.
REQ-009 rot_dir  output  1  direction driven to the rotator.
REQ-010 rot_result  input  [0:15]  rotator output, valid one cycle after rot_float/rot_dir.
REQ-011 row_addr  output  5  board row read address.
REQ-012 row_data  input  10  board row, valid the cycle after row_addr; bit c = column c, 1 = occupied.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 accepted  output  1  valid with done; 1 = rotation committed.
REQ-016 new_float  output  [0:15]  resulting piece, valid with done.
REQ-017 new_pos_x  output  5  resulting column, valid with done.

Function
REQ-018 FSM states: IDLE, LOAD, CAPTURE, FETCH, CHECK, DONE.
REQ-019 IDLE: on req=1, latch float_in, req_dir, pos_x and pos_y into rot_float, rot_dir and internal registers, then go to LOAD.
REQ-020 LOAD: hold rot_float/rot_dir for exactly one cycle, then go to CAPTURE.
REQ-021 CAPTURE: latch rot_result as the candidate, clear kick index, then go to FETCH.
REQ-022 FETCH: lasts 5 cycles; cycle r (0..3) drives row_addr = pos_y+r (5-bit); cycle r+1 stores row_data into row buffer r; then go to CHECK.
REQ-023 A buffered row whose address exceeds 19 (including 5-bit wrap) is forced to all-ones (floor), regardless of row_data.
REQ-024 CHECK: one kick per cycle, offsets in order 0, -1, +1 applied to pos_x.
REQ-025 Kick collision: any set candidate bit whose board column (pos_x+offset+j, evaluated signed 6-bit) is <0 or >9, or whose buffered cell is occupied.
REQ-026 First non-colliding kick: set accepted=1, new_float=candidate, new_pos_x=pos_x+offset; go to DONE.
REQ-027 All three kicks colliding: set accepted=0, new_float=latched float_in, new_pos_x=latched pos_x; go to DONE.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-029 accepted, new_float and new_pos_x hold their values until the next DONE.
REQ-030 req asserted in any non-IDLE state is ignored; it is not queued.
REQ-031 A req sampled at edge N produces done high in cycle N+9+k; k = index of the accepted kick (0..2), or 2 on rejection.
REQ-032 Input changes after acceptance do not affect the operation in progress.

Reset
REQ-033 rst_n=0 immediately forces IDLE and sets busy, done, accepted, rot_dir to 0, and new_float, new_pos_x, rot_float, row_addr and the row buffer to all-zero.
REQ-034 Reset asserted mid-operation aborts without a done pulse; the first req after release is processed normally.

Verification
REQ-035 Empty board, float_in=16'h0F00, pos_x=3, pos_y=0, req_dir=0 -> done at N+9, accepted=1, new_float=16'h2222, new_pos_x=3.
REQ-036 Empty board, float_in=16'h0F00, pos_x=8, pos_y=0, req_dir=0 -> kick 0 hits column 10, kick -1 succeeds -> done at N+10, accepted=1, new_pos_x=7.
REQ-037 float_in=16'h0F00, pos_x=3, pos_y=18 -> rows 20-21 are floor -> done at N+11, accepted=0, new_float=16'h0F00, new_pos_x=3.
REQ-038 Board row 2 column 5 occupied, float_in=16'h0F00, pos_x=3, pos_y=0, cw -> kick 0 collides, kick -1 succeeds -> done at N+10, accepted=1, new_pos_x=2.
REQ-039 Second req pulsed 3 cycles after the first -> exactly one done pulse, busy stays high throughout.
REQ-040 rst_n low during FETCH -> all outputs zero and no done; req after release -> done at N+9.
